// File: rtl/aud_codec_config.sv
// aud_codec_config
// Walks an audio codec through its power-up register table over a
// downstream I2C byte writer, then serves headphone-volume writes on
// request.
//
// Ports
//   CLOCK_50      in   50 MHz system clock, rising edge
//   reset         in   asynchronous active-low reset
//   start         in   pulse: abort and re-run the full table
//   vol_req       in   pulse: queue a headphone-volume write
//   vol_data[6:0] in   volume code, captured with vol_req
//   i2c_enable    out  one-cycle request to the I2C writer
//   i2c_addr1     out  slave address byte (SLAVE_ADDR)
//   i2c_addr2     out  codec register address
//   i2c_data      out  codec register data
//   i2c_done      in   writer idle flag (low while transferring)
//   busy          out  sequencer active (not IDLE, not ERR)
//   config_done   out  table finished since last start/reset
//   error         out  sticky handshake timeout
//   reg_index     out  table entry in progress
module aud_codec_config #(
  parameter logic [7:0]  SLAVE_ADDR = 8'h34,
  parameter int unsigned T_GAP      = 500,
  parameter int unsigned T_ACKTO    = 15
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic       vol_req,
  input  logic [6:0] vol_data,
  output logic       i2c_enable,
  output logic [7:0] i2c_addr1,
  output logic [6:0] i2c_addr2,
  output logic [8:0] i2c_data,
  input  logic       i2c_done,
  output logic       busy,
  output logic       config_done,
  output logic       error,
  output logic [3:0] reg_index
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LOAD      = 3'd1;
  localparam logic [2:0] ST_ISSUE     = 3'd2;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd3;
  localparam logic [2:0] ST_WAIT_DONE = 3'd4;
  localparam logic [2:0] ST_GAP       = 3'd5;
  localparam logic [2:0] ST_ERR       = 3'd6;

  localparam logic [3:0] LAST_INDEX = 4'd10;
  localparam logic [9:0] GAP_LOAD   = 10'(T_GAP);
  // Loaded one below T_ACKTO so ERR is entered exactly T_ACKTO cycles
  // after the enable pulse.
  localparam logic [7:0] ACK_LOAD   = 8'(T_ACKTO - 1);
  localparam logic [6:0] VOL_ADDR   = 7'h02;

  // Codec power-up table, returned as {addr2, data}.
  function automatic logic [15:0] table_entry(input logic [3:0] idx);
    logic [15:0] entry;
    case (idx)
      4'd0:    entry = {7'h0F, 9'h000};
      4'd1:    entry = {7'h00, 9'h017};
      4'd2:    entry = {7'h01, 9'h017};
      4'd3:    entry = {7'h02, 9'h079};
      4'd4:    entry = {7'h03, 9'h079};
      4'd5:    entry = {7'h04, 9'h012};
      4'd6:    entry = {7'h05, 9'h000};
      4'd7:    entry = {7'h06, 9'h000};
      4'd8:    entry = {7'h07, 9'h042};
      4'd9:    entry = {7'h08, 9'h000};
      4'd10:   entry = {7'h09, 9'h001};
      default: entry = {7'h00, 9'h000};
    endcase
    return entry;
  endfunction

  logic [2:0]  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [9:0]  gap_q, gap_d;
  logic [7:0]  ack_q, ack_d;
  logic        en_q, en_d;
  logic [7:0]  addr1_q, addr1_d;
  logic [6:0]  addr2_q, addr2_d;
  logic [8:0]  data_q, data_d;
  logic        busy_q, busy_d;
  logic        cfg_q, cfg_d;
  logic        err_q, err_d;
  logic        auto_q, auto_d;   // one-shot start after reset release
  logic        vmode_q, vmode_d; // current write is a volume write
  logic        pend_q, pend_d;
  logic [6:0]  vword_q, vword_d;
  logic        launch_vol_s;
  logic [15:0] entry_s;

  assign entry_s = table_entry(idx_q);

  // Next-state logic for the sequencer and its datapath registers.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    gap_d        = gap_q;
    ack_d        = ack_q;
    en_d         = 1'b0;
    addr1_d      = addr1_q;
    addr2_d      = addr2_q;
    data_d       = data_q;
    cfg_d        = cfg_q;
    err_d        = err_q;
    auto_d       = auto_q;
    vmode_d      = vmode_q;
    launch_vol_s = 1'b0;

    if (start) begin
      // Restart from any state; a pending volume write stays pending.
      state_d = ST_LOAD;
      idx_d   = 4'd0;
      cfg_d   = 1'b0;
      err_d   = 1'b0;
      auto_d  = 1'b0;
      vmode_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (auto_q) begin
            state_d = ST_LOAD;
            idx_d   = 4'd0;
            auto_d  = 1'b0;
            vmode_d = 1'b0;
          end else if (pend_q && cfg_q) begin
            state_d      = ST_LOAD;
            vmode_d      = 1'b1;
            launch_vol_s = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_LOAD: begin
          addr1_d = SLAVE_ADDR;
          if (vmode_q) begin
            addr2_d = VOL_ADDR;
            data_d  = {1'b1, 1'b0, vword_q};
          end else begin
            addr2_d = entry_s[15:9];
            data_d  = entry_s[8:0];
          end
          state_d = ST_ISSUE;
        end
        ST_ISSUE: begin
          if (i2c_done) begin
            en_d    = 1'b1;
            ack_d   = ACK_LOAD;
            state_d = ST_WAIT_BUSY;
          end else begin
            state_d = ST_ISSUE;
          end
        end
        ST_WAIT_BUSY: begin
          if (!i2c_done) begin
            state_d = ST_WAIT_DONE;
          end else if (ack_q == 8'd0) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end else begin
            ack_d = ack_q - 8'd1;
          end
        end
        ST_WAIT_DONE: begin
          if (i2c_done) begin
            gap_d   = GAP_LOAD;
            state_d = ST_GAP;
          end else begin
            state_d = ST_WAIT_DONE;
          end
        end
        ST_GAP: begin
          if (gap_q != 10'd0) begin
            gap_d = gap_q - 10'd1;
          end else if (vmode_q) begin
            vmode_d = 1'b0;
            state_d = ST_IDLE;
          end else if (idx_q == LAST_INDEX) begin
            cfg_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = ST_LOAD;
          end
        end
        ST_ERR: begin
          state_d = ST_ERR;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE) && (state_d != ST_ERR);
  end

  // Volume request capture: latest request wins, cleared when launched.
  always_comb begin
    if (vol_req) begin
      vword_d = vol_data;
      pend_d  = 1'b1;
    end else if (launch_vol_s) begin
      vword_d = vword_q;
      pend_d  = 1'b0;
    end else begin
      vword_d = vword_q;
      pend_d  = pend_q;
    end
  end

  // State and output registers.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      idx_q   <= 4'd0;
      gap_q   <= 10'd0;
      ack_q   <= 8'd0;
      en_q    <= 1'b0;
      addr1_q <= 8'd0;
      addr2_q <= 7'd0;
      data_q  <= 9'd0;
      busy_q  <= 1'b0;
      cfg_q   <= 1'b0;
      err_q   <= 1'b0;
      auto_q  <= 1'b1;
      vmode_q <= 1'b0;
      pend_q  <= 1'b0;
      vword_q <= 7'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      ack_q   <= ack_d;
      en_q    <= en_d;
      addr1_q <= addr1_d;
      addr2_q <= addr2_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      cfg_q   <= cfg_d;
      err_q   <= err_d;
      auto_q  <= auto_d;
      vmode_q <= vmode_d;
      pend_q  <= pend_d;
      vword_q <= vword_d;
    end
  end

  assign i2c_enable  = en_q;
  assign i2c_addr1   = addr1_q;
  assign i2c_addr2   = addr2_q;
  assign i2c_data    = data_q;
  assign busy        = busy_q;
  assign config_done = cfg_q;
  assign error       = err_q;
  assign reg_index   = idx_q;

endmodule

// File: tb/tb_aud_codec_config.sv
// Testbench for aud_codec_config: an I2C writer model plus a scoreboard
// of expected {addr2, data} writes built from the codec table and the
// latest-wins volume rule.
module tb_aud_codec_config;

  localparam int TGAP    = 100;
  localparam int TACK    = 15;
  localparam int WR_BUSY = 1400;
  localparam logic [7:0] SADDR = 8'h34;

  localparam logic [15:0] TBL [11] = '{
    {7'h0F, 9'h000}, {7'h00, 9'h017}, {7'h01, 9'h017}, {7'h02, 9'h079},
    {7'h03, 9'h079}, {7'h04, 9'h012}, {7'h05, 9'h000}, {7'h06, 9'h000},
    {7'h07, 9'h042}, {7'h08, 9'h000}, {7'h09, 9'h001}
  };

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic       start;
  logic       vol_req;
  logic [6:0] vol_data;
  logic       i2c_enable;
  logic [7:0] i2c_addr1;
  logic [6:0] i2c_addr2;
  logic [8:0] i2c_data;
  logic       i2c_done;
  logic       busy;
  logic       config_done;
  logic       error;
  logic [3:0] reg_index;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_en  = 0;
  int last_en = -1;
  int wr_cnt  = 0;
  int stab_bad = 0;
  logic wr_stuck  = 1'b0;
  logic chk_space = 1'b0;
  logic chk_stab  = 1'b0;
  logic [6:0] cap_a;
  logic [8:0] cap_d;
  logic [15:0] exp_q[$];

  aud_codec_config #(.SLAVE_ADDR(SADDR), .T_GAP(TGAP), .T_ACKTO(TACK)) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .start       (start),
    .vol_req     (vol_req),
    .vol_data    (vol_data),
    .i2c_enable  (i2c_enable),
    .i2c_addr1   (i2c_addr1),
    .i2c_addr2   (i2c_addr2),
    .i2c_data    (i2c_data),
    .i2c_done    (i2c_done),
    .busy        (busy),
    .config_done (config_done),
    .error       (error),
    .reg_index   (reg_index)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Writer model and write monitor, evaluated on the falling edge.
  initial begin
    logic [15:0] e;
    i2c_done = 1'b1;
    forever begin
      @(negedge CLOCK_50);
      if (i2c_enable) begin
        n_en++;
        if (chk_space && last_en >= 0)
          chk("spacing", 32'(((cyc - last_en) >= WR_BUSY + TGAP) &&
                             ((cyc - last_en) <= WR_BUSY + TGAP + 10)), 32'd1);
        last_en = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected_enable", 32'(n_en), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("addr1", 32'(i2c_addr1), 32'(SADDR));
          chk("addr2", 32'(i2c_addr2), 32'(e[15:9]));
          chk("data", 32'(i2c_data), 32'(e[8:0]));
        end
        cap_a = i2c_addr2;
        cap_d = i2c_data;
      end else if (chk_stab && reset && wr_cnt != 0) begin
        if (i2c_addr2 !== cap_a || i2c_data !== cap_d || i2c_addr1 !== SADDR)
          stab_bad++;
      end
      if (wr_stuck) begin
        i2c_done = 1'b1;
        wr_cnt   = 0;
      end else begin
        if (i2c_enable) wr_cnt = 1;
        else if (wr_cnt != 0) wr_cnt = wr_cnt + 1;
        if (wr_cnt >= 2 && wr_cnt <= WR_BUSY + 1) begin
          i2c_done = 1'b0;
        end else begin
          i2c_done = 1'b1;
          if (wr_cnt > WR_BUSY + 1) wr_cnt = 0;
        end
      end
    end
  end

  task automatic pulse_vol(input logic [6:0] v);
    vol_data = v;
    vol_req  = 1'b1;
    @(negedge CLOCK_50);
    vol_req  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
  endtask

  task automatic push_table(input int last);
    for (int i = 0; i <= last; i++) exp_q.push_back(TBL[i]);
  endtask

  task automatic wait_en(input string tag, input int n, input int limit);
    int k = 0;
    while (n_en < n && k < limit) begin
      @(negedge CLOCK_50);
      k++;
    end
    chk(tag, 32'(n_en >= n), 32'd1);
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int k = 0;
    while (busy && k < limit) begin
      @(negedge CLOCK_50);
      k++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    int k;
    int n0;
    logic early;
    logic [6:0] v;

    reset = 1'b0; start = 1'b0; vol_req = 1'b0; vol_data = 7'd0;
    repeat (3) @(negedge CLOCK_50);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cfg", 32'(config_done), 32'd0);
    chk("rst_err", 32'(error), 32'd0);
    chk("rst_idx", 32'(reg_index), 32'd0);
    chk("rst_en", 32'(i2c_enable), 32'd0);
    chk("rst_addr2", 32'(i2c_addr2), 32'd0);
    chk("rst_data", 32'(i2c_data), 32'd0);

    // Full table after reset release, with volume requests mid-sequence.
    push_table(10);
    chk_space = 1'b1;
    chk_stab  = 1'b1;
    reset = 1'b1;
    @(negedge CLOCK_50);
    chk("autostart_busy", 32'(busy), 32'd1);
    repeat ($urandom_range(2000, 5000)) @(negedge CLOCK_50);
    pulse_vol(7'h30);
    repeat ($urandom_range(1000, 3000)) @(negedge CLOCK_50);
    pulse_vol(7'($urandom_range(0, 127)));
    repeat ($urandom_range(1000, 3000)) @(negedge CLOCK_50);
    pulse_vol(7'h7F);
    chk("cfg_mid", 32'(config_done), 32'd0);
    exp_q.push_back({7'h02, 9'h17F});
    k = 0;
    while (!config_done && k < 20000) begin
      @(negedge CLOCK_50);
      k++;
    end
    chk_space = 1'b0;
    chk("cfg_done", 32'(config_done), 32'd1);
    chk("n_en_table", 32'(n_en), 32'd11);
    wait_en("vol_pending_write", 12, 3000);
    wait_idle("vol_pending_idle", 3000);
    chk("cfg_hold", 32'(config_done), 32'd1);
    chk("q_empty_1", 32'(exp_q.size()), 32'd0);

    // Volume writes after configuration: 0x55 then random codes.
    for (int r = 0; r < 3; r++) begin
      v = (r == 0) ? 7'h55 : 7'($urandom_range(0, 127));
      exp_q.push_back({7'h02, 2'b10, v});
      n0 = n_en;
      repeat ($urandom_range(1, 40)) @(negedge CLOCK_50);
      pulse_vol(v);
      wait_en("vol_write", n0 + 1, 100);
      wait_idle("vol_idle", 3000);
      chk("vol_cfg_hold", 32'(config_done), 32'd1);
      chk("vol_count", 32'(n_en), 32'(n0 + 1));
    end

    // Restart with a simultaneous volume request, then abort at index 5.
    chk_stab = 1'b0;
    push_table(5);
    vol_data = 7'($urandom_range(0, 127));
    vol_req  = 1'b1;
    start    = 1'b1;
    @(negedge CLOCK_50);
    vol_req  = 1'b0;
    start    = 1'b0;
    chk("restart_cfg_clr", 32'(config_done), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);
    k = 0;
    while (!(reg_index == 4'd5 && i2c_done == 1'b0) && k < 12000) begin
      @(negedge CLOCK_50);
      k++;
    end
    chk("reach_idx5", 32'(k < 12000), 32'd1);
    repeat (3) @(negedge CLOCK_50);
    pulse_start();
    chk("abort_idx", 32'(reg_index), 32'd0);
    push_table(7);
    early = 1'b0;
    k = 0;
    while (i2c_done == 1'b0 && k < 1500) begin
      if (i2c_enable) early = 1'b1;
      @(negedge CLOCK_50);
      k++;
    end
    chk("no_en_while_busy", 32'(early), 32'd0);

    // Reset during WAIT_DONE at index 7; writer then stuck idle.
    k = 0;
    while (!(reg_index == 4'd7 && i2c_done == 1'b0) && k < 14000) begin
      @(negedge CLOCK_50);
      k++;
    end
    chk("reach_idx7", 32'(k < 14000), 32'd1);
    repeat (5) @(negedge CLOCK_50);
    reset    = 1'b0;
    wr_stuck = 1'b1;
    @(negedge CLOCK_50);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_idx", 32'(reg_index), 32'd0);
    chk("mid_rst_addr2", 32'(i2c_addr2), 32'd0);
    chk("mid_rst_data", 32'(i2c_data), 32'd0);
    chk("mid_rst_cfg", 32'(config_done), 32'd0);
    chk("q_empty_2", 32'(exp_q.size()), 32'd0);
    push_table(0);
    @(negedge CLOCK_50);
    reset = 1'b1;

    // Handshake timeout: ERR exactly TACK cycles after the enable.
    k = 0;
    while (!i2c_enable && k < 50) begin
      @(negedge CLOCK_50);
      k++;
    end
    chk("stuck_enable", 32'(i2c_enable), 32'd1);
    early = 1'b0;
    for (int j = 1; j <= TACK; j++) begin
      @(negedge CLOCK_50);
      if (j < TACK && error) early = 1'b1;
    end
    chk("err_early", 32'(early), 32'd0);
    chk("err_set", 32'(error), 32'd1);
    chk("err_busy", 32'(busy), 32'd0);
    n0 = n_en;
    repeat (20) @(negedge CLOCK_50);
    chk("err_sticky", 32'(error), 32'd1);
    chk("err_no_enable", 32'(n_en), 32'(n0));
    push_table(0);
    pulse_start();
    chk("err_cleared", 32'(error), 32'd0);
    wait_en("err_reissue", n0 + 1, 50);
    chk("q_empty_3", 32'(exp_q.size()), 32'd0);
    chk("addr_stable", 32'(stab_bad), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
